// File: rtl/out_port_pkg.sv
// Shared types and constants for the output port buffer.
// Holds the serializer state encoding, default depth and level width.
package out_port_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2
  } state_t;

  localparam int DEF_DEPTH = 8;
  localparam int LVL_W     = 5;

endpackage

// File: rtl/out_fifo.sv
// Word FIFO behind the output port serializer.
// Level counter resolves full/empty; a write on a full FIFO is kept if a pop frees a slot.
module out_fifo
  import out_port_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic             pop,
  input  logic [15:0]      wr_data,
  output logic [15:0]      rd_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic             overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          rd;
  logic          acc;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign rd      = pop && !empty;
  assign acc     = wr && (!full || rd);
  assign rd_data = mem[rp];

  always_ff @(posedge clk) begin
    if (acc) mem[wp] <= wr_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp       <= '0;
      rp       <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (acc) wp <= wp + PW'(1);
      if (rd)  rp <= rp + PW'(1);
      if (acc && !rd)
        level <= level + LVL_W'(1);
      else if (rd && !acc)
        level <= level - LVL_W'(1);
      if (wr && !acc) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/out_port_buffer.sv
// Output port buffer: 16-bit word FIFO feeding a low-byte-first serializer.
// Define OUT_PORT_BUFFER_CHGDET_EN to write on wr_data change instead of wr_en.
module out_port_buffer
  import out_port_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [15:0]      wr_data,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic             overflow
);

  logic        we;
  logic        pop;
  logic [15:0] rd_data;
  logic [15:0] hold;
  state_t      state;

`ifdef OUT_PORT_BUFFER_CHGDET_EN
  logic [15:0] last;
  logic        unused_en;

  assign unused_en = wr_en;
  assign we        = (wr_data != last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last <= '0;
    else      last <= wr_data;
  end
`else
  assign we = wr_en;
`endif

  // Pop when the holding register is free or being vacated this edge.
  assign pop = !empty &&
               ((state == S_IDLE) ||
                ((state == S_HI) && tx_ready));

  out_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr       (we),
    .pop      (pop),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      hold     <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!empty) begin
            hold     <= rd_data;
            tx_data  <= rd_data[7:0];
            tx_valid <= 1'b1;
            state    <= S_LO;
          end
        end
        S_LO: begin
          if (tx_ready) begin
            tx_data <= hold[15:8];
            state   <= S_HI;
          end
        end
        S_HI: begin
          if (tx_ready) begin
            if (!empty) begin
              hold    <= rd_data;
              tx_data <= rd_data[7:0];
              state   <= S_LO;
            end else begin
              tx_valid <= 1'b0;
              state    <= S_IDLE;
            end
          end
        end
        default: begin
          tx_valid <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_out_port_buffer.sv
// Scoreboard bench for out_port_buffer (DEPTH=8).
// Expected bytes are queued at stimulus time; a negedge monitor checks each handshake.
module tb_out_port_buffer;
  import out_port_pkg::*;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             wr_en = 1'b0;
  logic [15:0]      wr_data = '0;
  logic             tx_ready = 1'b0;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             full;
  logic             empty;
  logic [LVL_W-1:0] level;
  logic             overflow;

  int total = 0;
  int passed = 0;
  int nbytes = 0;
  logic [7:0] expq[$];

  out_port_buffer #(
    .DEPTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst && tx_valid && tx_ready) begin
      nbytes++;
      if (expq.size() == 0) begin
        total++;
        $display("FAIL spurious_byte: got %0h required none", tx_data);
      end else begin
        chk("tx_byte", {24'd0, tx_data}, {24'd0, expq.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [15:0] w);
    expq.push_back(w[7:0]);
    expq.push_back(w[15:8]);
  endtask

  task automatic drain(input int budget);
    tx_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (expq.size() == 0 && !tx_valid) break;
      step();
    end
    chk("drain_left", expq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running required finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    step();
    step();
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);

`ifndef OUT_PORT_BUFFER_CHGDET_EN
    begin
      int cnt;
      logic [15:0] w;
      logic [15:0] tw [3];

      // first write on the first edge after release
      rst = 1'b1;
      tx_ready = 1'b1;
      wr_en = 1'b1;
      wr_data = 16'hBEEF;
      push_word(16'hBEEF);
      step();
      wr_en = 1'b0;
      chk("beef_level", level, 1);
      chk("beef_valid0", tx_valid, 0);
      step();
      chk("beef_valid1", tx_valid, 1);
      chk("beef_lo", tx_data, 8'hEF);
      step();
      chk("beef_hi", tx_data, 8'hBE);
      step();
      chk("beef_idle", tx_valid, 0);
      chk("beef_empty", empty, 1);

      tw[0] = 16'h1234;
      tw[1] = 16'h5678;
      tw[2] = 16'h9ABC;
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
        wr_en = 1'b1;
        wr_data = tw[i];
        push_word(tw[i]);
        step();
        if (i > 0) cnt += int'(tx_valid);
      end
      wr_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
        step();
        cnt += int'(tx_valid);
      end
      chk("no_bubble", cnt, 6);
      chk("tput_idle", tx_valid, 0);

      tx_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
        w = {8'(8'hA0 + i), 8'(8'h10 + i)};
        wr_en = 1'b1;
        wr_data = w;
        push_word(w);
        step();
      end
      wr_en = 1'b0;
      chk("fill_level", level, 8);
      chk("fill_full", full, 1);
      chk("fill_ovf", overflow, 0);
      chk("fill_hold", {tx_valid, tx_data}, {1'b1, 8'h10});

      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        step();
        chk("stall_hi", {tx_valid, tx_data}, {1'b1, 8'hA0});
      end

      tx_ready = 1'b1;
      wr_en = 1'b1;
      wr_data = 16'hC3D4;
      push_word(16'hC3D4);
      step();
      wr_en = 1'b0;
      tx_ready = 1'b0;
      chk("wrpop_level", level, 8);
      chk("wrpop_full", full, 1);
      chk("wrpop_ovf", overflow, 0);
      chk("next_lo", tx_data, 8'h11);

      wr_en = 1'b1;
      wr_data = 16'hDEAD;
      step();
      wr_en = 1'b0;
      chk("ovf_set", overflow, 1);
      chk("ovf_level", level, 8);
      drain(60);

      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
        wr_en = 1'b1;
        wr_data = 16'(16'h0101 * (i + 1));
        step();
      end
      wr_en = 1'b0;
      chk("mid_level", level, 3);
      chk("mid_lo", {tx_valid, tx_data}, {1'b1, 8'h01});
      // overflow is still set from the drop above
      chk("mid_ovf", overflow, 1);
      #2 rst = 1'b0;
      #1;
      chk("arst_valid", tx_valid, 0);
      chk("arst_level", level, 0);
      chk("arst_empty", empty, 1);
      chk("arst_full", full, 0);
      chk("arst_ovf", overflow, 0);
      chk("arst_data", tx_data, 0);
      step();
      rst = 1'b1;
      tx_ready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
        step();
        cnt += int'(tx_valid);
      end
      chk("post_rst_quiet", cnt, 0);

      wr_en = 1'b1;
      wr_data = 16'h5AA5;
      push_word(16'h5AA5);
      step();
      wr_en = 1'b0;
      drain(20);
    end
`else
    begin
      int nb0;
      rst = 1'b1;
      tx_ready = 1'b1;
      wr_en = 1'b1;
      wr_data = 16'h0000;
      step();
      step();
      chk("chg_none", level, 0);
      nb0 = nbytes;
      wr_data = 16'h0005;
      push_word(16'h0005);
      step();
      step();
      wr_data = 16'h0007;
      push_word(16'h0007);
      step();
      drain(30);
      for (int i = 0; i < 5; i++) step();
      chk("chg_bytes", nbytes - nb0, 4);
      chk("chg_idle", tx_valid, 0);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
